// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and fixed shift constants.
package alu_pkg;

    // Operation select encodings carried on aluop.
    typedef enum logic [2:0] {
        OP_ADD         = 3'b000,
        OP_SHIFT_LEFT  = 3'b001,
        OP_SHIFT_RIGHT = 3'b010,
        OP_XOR         = 3'b011,
        OP_OR          = 3'b100,
        OP_AND         = 3'b101,
        OP_RSVD6       = 3'b110,
        OP_RSVD7       = 3'b111
    } aluop_e;

    // Width of the aluop field.
    localparam int ALUOP_W = 3;

    // Fixed left shift used for the upper-immediate load.
    localparam int UIMM_SHIFT = 12;

    // Only the low bits of arg2 form the right-shift amount.
    localparam int SHAMT_W = 5;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between an ALU user (master) and the ALU (slave).
interface alu_if #(
    parameter int WIDTH = 32
);
    import alu_pkg::*;

    logic [WIDTH-1:0]   arg1;
    logic [WIDTH-1:0]   arg2;
    logic [ALUOP_W-1:0] aluop;
    logic [WIDTH-1:0]   result;

    modport master (
        output arg1,
        output arg2,
        output aluop,
        input  result
    );

    modport slave (
        input  arg1,
        input  arg2,
        input  aluop,
        output result
    );

endinterface : alu_if

// File: rtl/alu.sv
// Single-cycle ALU: combinational operation select feeding one output register.
// Result appears one clock after the operands; an asserted reset clears it at once.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] shamt;

    // Right-shift amount uses only the low bits of arg2; upper bits are ignored.
    assign shamt = bus.arg2[SHAMT_W-1:0];

    // Select the operation; reserved encodings resolve to zero so nothing undefined reaches the register.
    always_comb begin
        result_d = '0;
        case (bus.aluop)
            OP_ADD:         result_d = bus.arg1 + bus.arg2;
            OP_SHIFT_LEFT:  result_d = bus.arg2 << UIMM_SHIFT;
            OP_SHIFT_RIGHT: result_d = bus.arg1 >> shamt;
            OP_XOR:         result_d = bus.arg1 ^ bus.arg2;
            OP_OR:          result_d = bus.arg1 | bus.arg2;
            OP_AND:         result_d = bus.arg1 & bus.arg2;
            default:        result_d = '0;
        endcase
    end

    // Output register: cleared asynchronously while rst is low, otherwise loads every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

endmodule : alu

// File: tb/tb_alu.sv
// Directed-vector bench for the ALU with hand-computed expected results.
module tb_alu;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_if #(.WIDTH(WIDTH)) bus ();

    alu #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge so they are stable at the next rising edge.
    task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.aluop = op;
        bus.arg1  = a;
        bus.arg2  = b;
    endtask

    // Drive, let one rising edge pass, then sample just after it.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp);
        drive(op, a, b);
        @(posedge clk);
        #1;
        check(tag, bus.result, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst       = 1'b0;
        bus.aluop = OP_ADD;
        bus.arg1  = 32'd5;
        bus.arg2  = 32'd2;

        #1;
        check("reset_initial", bus.result, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", bus.result, 32'd0);

        // First edge after release captures the operands present at that edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_before_edge", bus.result, 32'd0);
        @(posedge clk);
        #1;
        check("first_edge_after_release", bus.result, 32'd7);

        run_op("add_5_2",        OP_ADD, 32'd5, 32'd2, 32'd7);
        run_op("add_wrap",       OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("add_large",      OP_ADD, 32'h7FFF_FFFF, 32'h8000_0003, 32'h0000_0002);

        run_op("shl_one",        OP_SHIFT_LEFT, 32'd0, 32'd1, 32'd4096);
        run_op("shl_fffff",      OP_SHIFT_LEFT, 32'd0, 32'h000F_FFFF, 32'hFFFF_F000);
        run_op("shl_arg1_ignored", OP_SHIFT_LEFT, 32'hFFFF_FFFF, 32'd1, 32'd4096);
        run_op("shl_discard_top", OP_SHIFT_LEFT, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_F000);

        run_op("shr_4_by_1",     OP_SHIFT_RIGHT, 32'd4, 32'd1, 32'd2);
        run_op("shr_amt_masked", OP_SHIFT_RIGHT, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000);
        run_op("shr_by_0",       OP_SHIFT_RIGHT, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        run_op("shr_by_31",      OP_SHIFT_RIGHT, 32'h8000_0001, 32'd31, 32'd1);
        run_op("shr_upper_ign",  OP_SHIFT_RIGHT, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'hDEAD_BEEF);
        run_op("shr_by_4",       OP_SHIFT_RIGHT, 32'hF000_00F0, 32'd4, 32'h0F00_000F);

        run_op("xor_1010_1001",  OP_XOR, 32'b1010, 32'b1001, 32'b0011);
        run_op("and_1010_1001",  OP_AND, 32'b1010, 32'b1001, 32'b1000);
        run_op("or_1100_0011",   OP_OR,  32'b1100, 32'b0011, 32'b1111);
        run_op("xor_wide",       OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
        run_op("or_wide",        OP_OR,  32'hA000_0005, 32'h0500_00A0, 32'hA500_00A5);
        run_op("and_wide",       OP_AND, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000);

        run_op("rsvd_110",       3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run_op("rsvd_111",       3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

        // Reset asserted between edges clears result at once and drops the pending op.
        run_op("pre_reset_add",  OP_ADD, 32'd5, 32'd2, 32'd7);
        #2;
        rst = 1'b0;
        #1;
        check("reset_immediate", bus.result, 32'd0);
        @(posedge clk);
        #1;
        check("reset_blocks_edge", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_release_hold", bus.result, 32'd0);
        @(posedge clk);
        #1;
        check("reset_release_add", bus.result, 32'd7);

        // Operands changed just after an edge must not show until the next edge.
        run_op("lat_base",       OP_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0);
        bus.aluop = OP_ADD;
        bus.arg1  = 32'd100;
        bus.arg2  = 32'd23;
        #3;
        check("lat_hold", bus.result, 32'h0000_00F0);
        @(posedge clk);
        #1;
        check("lat_update", bus.result, 32'd123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu
